// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C responder slice.
//   i2c_state_t      : responder FSM states
//   I2C_GCALL_ADDR   : general-call address (7'h00)
//   I2C_SYNC_STAGES  : flip-flop depth of the SCL/SDA input synchronizers
// ---------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_DATA     = 3'd3,
      ST_DATA_ACK = 3'd4,
      ST_IGNORE   = 3'd5
   } i2c_state_t;

   localparam logic [6:0] I2C_GCALL_ADDR  = 7'h00;
   localparam int         I2C_SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_sync_edge.sv
// ---------------------------------------------------------------------------
// i2c_sync_edge
// Brings an asynchronous bus pin into the clk domain and flags its edges.
// Ports:
//   clk    in  system clock
//   rst    in  synchronous active-high reset
//   i_pad  in  raw asynchronous pin value
//   level  out synchronized level, aligned with rise/fall
//   rise   out one-cycle pulse on a 0->1 transition
//   fall   out one-cycle pulse on a 1->0 transition
// Pad edge to rise/fall pulse is STAGES+1 clk cycles.
// ---------------------------------------------------------------------------
module i2c_sync_edge
   import i2c_pkg::*;
#(
   parameter int STAGES = I2C_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pad,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_level;
   logic              r_rise;
   logic              r_fall;
   logic              w_synced;

   assign w_synced = r_sync[STAGES-1];

   // Synchronizer chain followed by the edge register. Everything resets to 1
   // because an idle I2C bus floats high, so leaving reset never looks like
   // a falling edge. The edge pulses are registered together with the level
   // so level, rise and fall all describe the same instant.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '1;
         r_level <= 1'b1;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[STAGES-2:0], i_pad};
         r_level <= w_synced;
         r_rise  <= w_synced & ~r_level;
         r_fall  <= ~w_synced & r_level;
      end
   end

   assign level = r_level;
   assign rise  = r_rise;
   assign fall  = r_fall;

endmodule

// File: rtl/i2c_slave_core.sv
// ---------------------------------------------------------------------------
// i2c_slave_core
// Write-only I2C responder. Oversamples SCL/SDA, detects START/STOP, ACKs
// its own address with R/W=0 and then ACKs and delivers every data byte.
// Ports:
//   clk         in    system clock
//   rst         in    synchronous active-high reset
//   SCL         in    I2C clock from the master (asynchronous)
//   SDA         inout I2C data, open-drain (only ever driven low)
//   rx_addr_o   out   [6:0] address of the current matched transfer
//   rx_data_o   out   [7:0] last received data byte
//   rx_valid_o  out   one-cycle pulse when rx_data_o updates
//   busy_o      out   high from START until STOP
// Build option:
//   I2C_SLAVE_GCALL_EN  when defined, address 7'h00 (write) is also ACKed.
// ---------------------------------------------------------------------------
module i2c_slave_core
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h72
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SCL,
   inout  wire        SDA,
   output logic [6:0] rx_addr_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       busy_o
);

   logic       w_sdaPad;
   logic       w_sclLevel, w_sclRise, w_sclFall;
   logic       w_sdaLevel, w_sdaRise, w_sdaFall;
   logic       w_start, w_stop, w_addrHit;

   i2c_state_t r_state, w_stateNxt;
   logic [2:0] r_bitCnt, w_bitCntNxt;
   logic [7:0] r_shift, w_shiftNxt;
   logic       r_byteDone, w_byteDoneNxt;
   logic       r_sdaOe, w_sdaOeNxt;
   logic [6:0] r_rxAddr, w_rxAddrNxt;
   logic [7:0] r_rxData, w_rxDataNxt;
   logic       r_rxValid, w_rxValidNxt;
   logic       r_busy, w_busyNxt;

   assign w_sdaPad = SDA;

   i2c_sync_edge #(.STAGES(I2C_SYNC_STAGES)) u_sclSync (
      .clk   (clk),
      .rst   (rst),
      .i_pad (SCL),
      .level (w_sclLevel),
      .rise  (w_sclRise),
      .fall  (w_sclFall)
   );

   i2c_sync_edge #(.STAGES(I2C_SYNC_STAGES)) u_sdaSync (
      .clk   (clk),
      .rst   (rst),
      .i_pad (w_sdaPad),
      .level (w_sdaLevel),
      .rise  (w_sdaRise),
      .fall  (w_sdaFall)
   );

   // SDA only legally changes while SCL is low, so an SDA edge seen while
   // SCL is high is a bus condition: falling is START, rising is STOP.
   assign w_start = w_sdaFall & w_sclLevel;
   assign w_stop  = w_sdaRise & w_sclLevel;

`ifdef I2C_SLAVE_GCALL_EN
   assign w_addrHit = ~r_shift[0] &
                      ((r_shift[7:1] == SLAVE_ADDR) || (r_shift[7:1] == I2C_GCALL_ADDR));
`else
   assign w_addrHit = ~r_shift[0] & (r_shift[7:1] == SLAVE_ADDR);
`endif

   // State and datapath registers. The SDA enable is registered here, so the
   // pad changes one clk after the detected SCL fall, which gives data hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bitCnt   <= 3'd0;
         r_shift    <= 8'h00;
         r_byteDone <= 1'b0;
         r_sdaOe    <= 1'b0;
         r_rxAddr   <= 7'h00;
         r_rxData   <= 8'h00;
         r_rxValid  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_stateNxt;
         r_bitCnt   <= w_bitCntNxt;
         r_shift    <= w_shiftNxt;
         r_byteDone <= w_byteDoneNxt;
         r_sdaOe    <= w_sdaOeNxt;
         r_rxAddr   <= w_rxAddrNxt;
         r_rxData   <= w_rxDataNxt;
         r_rxValid  <= w_rxValidNxt;
         r_busy     <= w_busyNxt;
      end
   end

   // Next-state logic. START and STOP override everything else, with START
   // checked first so it also wins over a simultaneous SCL fall. Bits are
   // shifted on SCL rise; the byte is acted on at the SCL fall that follows
   // the 8th bit, which is exactly when the ACK slot begins. r_byteDone is
   // needed because the 3-bit counter has already wrapped back to 0 by then.
   always_comb begin
      w_stateNxt    = r_state;
      w_bitCntNxt   = r_bitCnt;
      w_shiftNxt    = r_shift;
      w_byteDoneNxt = r_byteDone;
      w_sdaOeNxt    = r_sdaOe;
      w_rxAddrNxt   = r_rxAddr;
      w_rxDataNxt   = r_rxData;
      w_rxValidNxt  = 1'b0;
      w_busyNxt     = r_busy;

      if (w_start) begin
         w_stateNxt    = ST_ADDR;
         w_bitCntNxt   = 3'd0;
         w_byteDoneNxt = 1'b0;
         w_sdaOeNxt    = 1'b0;
         w_busyNxt     = 1'b1;
      end else if (w_stop) begin
         w_stateNxt    = ST_IDLE;
         w_bitCntNxt   = 3'd0;
         w_byteDoneNxt = 1'b0;
         w_sdaOeNxt    = 1'b0;
         w_busyNxt     = 1'b0;
      end else begin
         case (r_state)
            ST_ADDR, ST_DATA: begin
               if (w_sclRise) begin
                  w_shiftNxt  = {r_shift[6:0], w_sdaLevel};
                  w_bitCntNxt = r_bitCnt + 3'd1;
                  if (r_bitCnt == 3'd7) begin
                     w_byteDoneNxt = 1'b1;
                  end
               end else if (w_sclFall && r_byteDone) begin
                  w_byteDoneNxt = 1'b0;
                  if (r_state == ST_ADDR) begin
                     if (w_addrHit) begin
                        w_stateNxt  = ST_ADDR_ACK;
                        w_sdaOeNxt  = 1'b1;
                        w_rxAddrNxt = r_shift[7:1];
                     end else begin
                        w_stateNxt  = ST_IGNORE;
                     end
                  end else begin
                     w_stateNxt   = ST_DATA_ACK;
                     w_sdaOeNxt   = 1'b1;
                     w_rxDataNxt  = r_shift;
                     w_rxValidNxt = 1'b1;
                  end
               end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
               if (w_sclFall) begin
                  w_stateNxt    = ST_DATA;
                  w_sdaOeNxt    = 1'b0;
                  w_bitCntNxt   = 3'd0;
                  w_byteDoneNxt = 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign SDA        = r_sdaOe ? 1'b0 : 1'bz;
   assign rx_addr_o  = r_rxAddr;
   assign rx_data_o  = r_rxData;
   assign rx_valid_o = r_rxValid;
   assign busy_o     = r_busy;

endmodule

// File: tb/tb_i2c_slave_core.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_core
// Directed bench for i2c_slave_core. A simple bit-banged master drives SCL
// and pulls SDA low through an open-drain driver; a pullup restores SDA.
// Each scenario task drives the bus and checks the responder's outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_core;

   logic       clk;
   logic       rst;
   logic       scl;
   logic       masterSdaOe;
   wire        sdaBus;
   logic [6:0] rxAddr;
   logic [7:0] rxData;
   logic       rxValid;
   logic       busy;

   int         checks;
   int         errors;
   int         pulseCount;
   logic [7:0] pulseData [$];

   assign sdaBus = masterSdaOe ? 1'b0 : 1'bz;
   pullup (sdaBus);

   i2c_slave_core #(.SLAVE_ADDR(7'h72)) dut (
      .clk        (clk),
      .rst        (rst),
      .SCL        (scl),
      .SDA        (sdaBus),
      .rx_addr_o  (rxAddr),
      .rx_data_o  (rxData),
      .rx_valid_o (rxValid),
      .busy_o     (busy)
   );

   // 100 MHz system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record every valid pulse; a stuck valid shows up as extra entries
   always @(negedge clk) begin
      if (rxValid === 1'b1) begin
         pulseCount++;
         pulseData.push_back(rxData);
      end
   end

   // Safety net so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] watchdog");
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clearPulses();
      pulseCount = 0;
      pulseData.delete();
   endtask

   // START from idle, or repeated START when SCL is currently low
   task automatic sendStart();
      if (scl == 1'b0) begin
         masterSdaOe = 1'b0;
         waitCycles(5);
         scl = 1'b1;
         waitCycles(5);
      end
      masterSdaOe = 1'b1;
      waitCycles(10);
      scl = 1'b0;
      waitCycles(5);
   endtask

   task automatic sendBit(input logic b);
      masterSdaOe = ~b;
      waitCycles(5);
      scl = 1'b1;
      waitCycles(10);
      scl = 1'b0;
      waitCycles(5);
   endtask

   task automatic getAck(output logic ack);
      masterSdaOe = 1'b0;
      waitCycles(5);
      scl = 1'b1;
      waitCycles(5);
      ack = sdaBus;
      waitCycles(5);
      scl = 1'b0;
      waitCycles(5);
   endtask

   task automatic sendByte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         sendBit(b[i]);
      end
      getAck(ack);
   endtask

   task automatic sendStop();
      masterSdaOe = 1'b1;
      waitCycles(5);
      scl = 1'b1;
      waitCycles(5);
      masterSdaOe = 1'b0;
      waitCycles(10);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      waitCycles(4);
      rst = 1'b0;
      waitCycles(2);
      checks++;
      if (rxAddr !== 7'h00) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00", rxAddr); end
      checks++;
      if (rxData !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", rxData); end
      checks++;
      if (rxValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rxValid); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (sdaBus !== 1'b1) begin errors++; $display("[TB] FAIL reset_sda: got %b expected 1", sdaBus); end
   endtask

   task automatic test_write_match();
      logic ack;
      clearPulses();
      sendStart();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL match_busy_start: got %b expected 1", busy); end
      sendByte(8'hE4, ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("[TB] FAIL match_addr_ack: got %b expected 0", ack); end
      sendByte(8'h45, ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("[TB] FAIL match_data_ack: got %b expected 0", ack); end
      sendStop();
      checks++;
      if (pulseCount !== 1) begin errors++; $display("[TB] FAIL match_pulses: got %0d expected 1", pulseCount); end
      checks++;
      if (rxData !== 8'h45) begin errors++; $display("[TB] FAIL match_data: got %h expected 45", rxData); end
      checks++;
      if (rxAddr !== 7'h72) begin errors++; $display("[TB] FAIL match_addr: got %h expected 72", rxAddr); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL match_busy_stop: got %b expected 0", busy); end
   endtask

   task automatic test_addr_mismatch();
      logic ack;
      clearPulses();
      sendStart();
      sendByte(8'h82, ack);
      checks++;
      if (ack !== 1'b1) begin errors++; $display("[TB] FAIL mismatch_nack: got %b expected 1", ack); end
      sendByte(8'h92, ack);
      checks++;
      if (ack !== 1'b1) begin errors++; $display("[TB] FAIL mismatch_data_nack: got %b expected 1", ack); end
      sendStop();
      checks++;
      if (pulseCount !== 0) begin errors++; $display("[TB] FAIL mismatch_pulses: got %0d expected 0", pulseCount); end
      checks++;
      if (rxData !== 8'h45) begin errors++; $display("[TB] FAIL mismatch_data_kept: got %h expected 45", rxData); end
   endtask

   task automatic test_read_nack();
      logic ack;
      clearPulses();
      sendStart();
      sendByte(8'hE5, ack);
      checks++;
      if (ack !== 1'b1) begin errors++; $display("[TB] FAIL read_nack: got %b expected 1", ack); end
      sendStart();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL read_rstart_busy: got %b expected 1", busy); end
      sendByte(8'hE4, ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("[TB] FAIL read_rstart_ack: got %b expected 0", ack); end
      sendByte(8'h5A, ack);
      sendStop();
      checks++;
      if (pulseCount !== 1 || rxData !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL read_rstart_data: got %0d pulses data %h expected 1 pulse data 5a", pulseCount, rxData);
      end
   endtask

   task automatic test_back_to_back();
      logic ack;
      logic [7:0] bytes [3];
      bytes[0] = 8'h01;
      bytes[1] = 8'h02;
      bytes[2] = 8'h03;
      clearPulses();
      sendStart();
      sendByte(8'hE4, ack);
      for (int i = 0; i < 3; i++) begin
         sendByte(bytes[i], ack);
         checks++;
         if (ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ack%0d: got %b expected 0", i, ack); end
      end
      sendStop();
      checks++;
      if (pulseCount !== 3) begin
         errors++;
         $display("[TB] FAIL b2b_pulses: got %0d expected 3", pulseCount);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (pulseData[i] !== bytes[i]) begin
               errors++;
               $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, pulseData[i], bytes[i]);
            end
         end
      end
   endtask

   task automatic test_abort_reset();
      logic ack;
      logic [7:0] addrByte;
      addrByte = 8'hE4;
      clearPulses();
      sendStart();
      sendByte(8'hE4, ack);
      for (int i = 0; i < 4; i++) begin
         sendBit(1'b1);
      end
      sendStop();
      checks++;
      if (pulseCount !== 0) begin errors++; $display("[TB] FAIL abort_pulses: got %0d expected 0", pulseCount); end
      checks++;
      if (rxData !== 8'h03 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_state: got data %h busy %b expected data 03 busy 0", rxData, busy);
      end
      sendStart();
      for (int i = 7; i >= 0; i--) begin
         sendBit(addrByte[i]);
      end
      masterSdaOe = 1'b0;
      waitCycles(5);
      scl = 1'b1;
      waitCycles(3);
      checks++;
      if (sdaBus !== 1'b0) begin errors++; $display("[TB] FAIL abort_ack_driven: got %b expected 0", sdaBus); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (sdaBus !== 1'b1) begin errors++; $display("[TB] FAIL abort_sda_release: got %b expected 1", sdaBus); end
      checks++;
      if (rxAddr !== 7'h00 || rxData !== 8'h00 || rxValid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_outputs: got addr %h data %h valid %b busy %b expected all 0",
                  rxAddr, rxData, rxValid, busy);
      end
      rst = 1'b0;
      waitCycles(2);
      scl = 1'b0;
      waitCycles(5);
      sendBit(1'b0);
      sendStop();
      checks++;
      if (pulseCount !== 0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_after_reset: got %0d pulses busy %b expected 0 pulses busy 0", pulseCount, busy);
      end
   endtask

   task automatic test_gcall();
      logic ack;
      logic expAck;
      int   expPulses;
      logic [7:0] expData;
`ifdef I2C_SLAVE_GCALL_EN
      expAck    = 1'b0;
      expPulses = 1;
      expData   = 8'hA5;
`else
      expAck    = 1'b1;
      expPulses = 0;
      expData   = 8'h00;
`endif
      clearPulses();
      sendStart();
      sendByte(8'h00, ack);
      checks++;
      if (ack !== expAck) begin errors++; $display("[TB] FAIL gcall_addr_ack: got %b expected %b", ack, expAck); end
      sendByte(8'hA5, ack);
      sendStop();
      checks++;
      if (pulseCount !== expPulses) begin
         errors++;
         $display("[TB] FAIL gcall_pulses: got %0d expected %0d", pulseCount, expPulses);
      end
      checks++;
      if (rxData !== expData) begin errors++; $display("[TB] FAIL gcall_data: got %h expected %h", rxData, expData); end
      checks++;
      if (rxAddr !== 7'h00) begin errors++; $display("[TB] FAIL gcall_addr: got %h expected 00", rxAddr); end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      pulseCount  = 0;
      rst         = 1'b1;
      scl         = 1'b1;
      masterSdaOe = 1'b0;
      test_reset();
      waitCycles(10);
      test_write_match();
      test_addr_mismatch();
      test_read_nack();
      test_back_to_back();
      test_abort_reset();
      test_gcall();
      waitCycles(10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_core.md
# i2c_slave_core

Write-only I2C responder (slave) that sits on the same SCL/SDA bus as `I2C_Core` and is its bus partner. It oversamples SCL/SDA on the system clock and detects START/STOP. It ACKs a 7-bit address matching `SLAVE_ADDR` with R/W=0, then shifts in and ACKs data bytes. Each received byte is presented to fabric logic as a one-cycle valid pulse.

## Interface
- `SLAVE_ADDR`, 7'h72, 7-bit address this responder answers to.
- `clk  input  1  system clock; all logic on rising edge.`
- `rst  input  1  reset, synchronous, active-high.`
- `SCL  input  1  I2C clock from master; asynchronous to clk.`
- `SDA  inout  1  I2C data, open-drain: driven 0 or released to 1'bz, never driven 1.`
- `rx_addr_o  output  7  address of the current matched transfer.`
- `rx_data_o  output  8  last received data byte.`
- `rx_valid_o  output  1  one-cycle pulse when rx_data_o updates.`
- `busy_o  output  1  high from START until STOP.`

## Operation
- SCL and SDA pad input (`sda_pad_i`) pass through 2-FF synchronizers, then one edge register. This gives `scl_rise`, `scl_fall`, `start_det` (SDA 1→0 while SCL high) and `stop_det` (SDA 0→1 while SCL high).
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: `start_det` → ADDR; bit counter = 0; `busy_o` = 1.
- ADDR: shift SDA in MSB-first on each `scl_rise`. The 8th bit ends the byte. At the next `scl_fall`:
  - byte[7:1]==SLAVE_ADDR and byte[0]==0 → ADDR_ACK, drive SDA low, `rx_addr_o` = byte[7:1].
  - Otherwise → IGNORE; SDA stays released, which is a NACK.
- ADDR_ACK: hold SDA low through the 9th SCL high phase. At the following `scl_fall`, release SDA → DATA, counter = 0.
- DATA: shift 8 bits as in ADDR. At the `scl_fall` after the 8th bit: `rx_data_o` = byte, `rx_valid_o` = 1 for one cycle, drive SDA low → DATA_ACK.
- DATA_ACK: release SDA at the next `scl_fall` → DATA. This allows unlimited bytes per transfer.
- IGNORE: SDA released; wait for START or STOP.
- `start_det` in any state (repeated START): release SDA, counter = 0 → ADDR. `busy_o` stays 1.
- `stop_det` in any state: release SDA → IDLE, `busy_o` = 0. A partial byte is discarded with no `rx_valid_o`.
- Bit counter is 3 bits and wraps 7→0 at byte end.

## Timing
- Reset values: `rx_addr_o`=0, `rx_data_o`=0, `rx_valid_o`=0, `busy_o`=0, SDA released. State = IDLE.
- Reset mid-transfer releases SDA immediately. Bus activity is ignored until the next START.
- Detection latency: 3 clk cycles from pad edge to internal event.
- SDA output enable is registered. It changes 1 cycle after the detected `scl_fall`, i.e. 4 clk after the pad falls. This satisfies data hold after SCL falls.
- `rx_valid_o` asserts in the same cycle SDA is driven for the data ACK.
- SCL must be low for at least 6 clk cycles and high for at least 6 clk cycles. The master's 100/400 kHz timing at 100 MHz clk meets this with large margin.
- Simultaneous `start_det` and `stop_det` cannot occur (both need an SDA edge). Same-cycle `scl_fall` and `start_det`: START wins.

## Configuration
- `I2C_SLAVE_GCALL_EN` defined: address 7'h00 with R/W=0 is also ACKed and handled exactly as a match, with `rx_addr_o` = 0.
- Not defined: 7'h00 goes to IGNORE and is NACKed, like any other mismatch.

## Structure
- Shared package `i2c_pkg` holds:
  - the state enum for IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE;
  - constant `I2C_GCALL_ADDR` = 7'h00;
  - constant `I2C_SYNC_STAGES` = 2.
- Sub-module `i2c_sync_edge`: synchronizer plus edge detect, with outputs `level`, `rise`, `fall`. It is instantiated once for SCL and once for SDA.
- The top module owns the FSM, shift register, bit counter and open-drain SDA assign (`sda_oe ? 1'b0 : 1'bz`).

## Test plan
- Bench master `I2C_Core` writes addr 7'h72, data 8'h45 → SDA pulled low at both ACK bits; `rx_valid_o` pulses once; `rx_data_o`=8'h45; `rx_addr_o`=7'h72; `busy_o` falls after STOP.
- Master writes addr 7'h41, data 8'h92 → no ACK (SDA stays 1 at 9th clock); `rx_valid_o` never asserts; `rx_data_o` keeps 8'h45.
- Address 7'h72 with R/W=1 → NACK; state goes to IGNORE; next START with 7'h72 write is ACKed.
- Three data bytes 8'h01, 8'h02, 8'h03 in one transfer → three `rx_valid_o` pulses in order, each ACKed.
- STOP after 4 data bits, then `rst` asserted during a later address ACK → no `rx_valid_o`; SDA released the cycle after `rst`; all outputs return to 0.
- With `I2C_SLAVE_GCALL_EN`, write to 7'h00 with data 8'hA5 → ACKed, `rx_data_o`=8'hA5. Without the macro the same write is NACKed.
